button_event_ctrl: RTL and testbench

//  Scheduler behind the debounce stage. It takes C_CHANNELS debounced button levels and turns them

---
 rtl/button_event_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Button event scheduler: per-channel PRESS/RELEASE/LONG detection, round-robin arbitration into
// a first-word fall-through event FIFO. Define BTN_EVT_REPEAT_EN to enable auto-repeat while held.
module button_event_ctrl #(
    parameter int unsigned C_CLK_FRQ    = 100000000,
    parameter int unsigned C_CHANNELS   = 4,
    parameter int unsigned C_LONG_MS    = 500,
    parameter int unsigned C_REPEAT_MS  = 100,
    parameter int unsigned C_FIFO_DEPTH = 8,
    localparam int unsigned CW          = $clog2(C_CHANNELS),
    localparam int unsigned AW          = $clog2(C_FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [C_CHANNELS-1:0] btn,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CW+1:0]         evt_data,
    output logic [AW:0]           evt_fill,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int unsigned TICK_DIV = C_CLK_FRQ / 1000;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MS_MAX   = (C_LONG_MS > C_REPEAT_MS) ? C_LONG_MS : C_REPEAT_MS;
    localparam int unsigned MSW      = $clog2(MS_MAX + 1);
    localparam int unsigned EW       = CW + 2;
    localparam int unsigned FW       = AW + 1;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [1:0] EV_REPEAT  = 2'b11;
`endif

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

    function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
        return (base + off) % C_CHANNELS;
    endfunction

    // Millisecond prescaler
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) presc_q <= '0;
        else             presc_q <= presc_q + PW'(1);
    end

    // Per-channel FSMs
    state_e                state_q [C_CHANNELS];
    state_e                state_d [C_CHANNELS];
    logic [MSW-1:0]        cnt_q   [C_CHANNELS];
    logic [MSW-1:0]        cnt_d   [C_CHANNELS];
    logic [C_CHANNELS-1:0] prev_q;
    logic [C_CHANNELS-1:0] gen;
    logic [1:0]            gen_type [C_CHANNELS];

    always_comb begin
        for (int i = 0; i < C_CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            gen[i]      = 1'b0;
            gen_type[i] = EV_PRESS;
            case (state_q[i])
                StIdle: begin
                    if (btn[i] && !prev_q[i]) begin
                        gen[i]     = 1'b1;
                        state_d[i] = StPressed;
                        cnt_d[i]   = '0;
                    end
                end
                StPressed: begin
                    if (!btn[i] && prev_q[i]) begin
                        gen[i]      = 1'b1;
                        gen_type[i] = EV_RELEASE;
                        state_d[i]  = StIdle;
                    end else if (tick) begin
                        if (cnt_q[i] == MSW'(C_LONG_MS - 1)) begin
                            gen[i]      = 1'b1;
                            gen_type[i] = EV_LONG;
                            state_d[i]  = StHeld;
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + MSW'(1);
                        end
                    end
                end
                StHeld: begin
                    if (!btn[i] && prev_q[i]) begin
                        gen[i]      = 1'b1;
                        gen_type[i] = EV_RELEASE;
                        state_d[i]  = StIdle;
`ifdef BTN_EVT_REPEAT_EN
                    end else if (tick) begin
                        if (cnt_q[i] == MSW'(C_REPEAT_MS - 1)) begin
                            gen[i]      = 1'b1;
                            gen_type[i] = EV_REPEAT;
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + MSW'(1);
                        end
`endif
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // Pending slots and round-robin arbiter
    logic [C_CHANNELS-1:0] slot_full_q;
    logic [C_CHANNELS-1:0] slot_full_d;
    logic [1:0]            slot_type_q [C_CHANNELS];
    logic [1:0]            slot_type_d [C_CHANNELS];
    logic [CW-1:0]         rr_q;
    logic [CW-1:0]         grant_idx;
    logic [C_CHANNELS-1:0] grant_oh;
    logic                  grant_any;
    logic                  fifo_full;
    logic                  fifo_accept;
    logic                  rd_en;
    logic                  lost;
    logic                  ovf_q;

    assign rd_en       = evt_valid && evt_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign fifo_accept = !fifo_full || rd_en;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int off = 0; off < C_CHANNELS; off++) begin
            if (!grant_any && slot_full_q[wrap_idx(int'(rr_q), off)]) begin
                grant_any = 1'b1;
                grant_idx = CW'(wrap_idx(int'(rr_q), off));
            end
        end
        if (!fifo_accept) grant_any = 1'b0;
        if (grant_any) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        slot_full_d = slot_full_q;
        lost        = 1'b0;
        for (int i = 0; i < C_CHANNELS; i++) begin
            slot_type_d[i] = slot_type_q[i];
            if (grant_oh[i]) slot_full_d[i] = 1'b0;
            if (gen[i]) begin
                if (slot_full_q[i] && !grant_oh[i]) begin
                    lost = 1'b1;
                end else begin
                    slot_full_d[i] = 1'b1;
                    slot_type_d[i] = gen_type[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= btn;
        if (rst) begin
            slot_full_q <= '0;
            rr_q        <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < C_CHANNELS; i++) begin
                state_q[i]     <= StIdle;
                cnt_q[i]       <= '0;
                slot_type_q[i] <= '0;
            end
        end else begin
            slot_full_q <= slot_full_d;
            if (grant_any) rr_q <= CW'(wrap_idx(int'(grant_idx), 1));
            if (ovf_clr)   ovf_q <= 1'b0;
            else if (lost) ovf_q <= 1'b1;
            for (int i = 0; i < C_CHANNELS; i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                slot_type_q[i] <= slot_type_d[i];
            end
        end
    end

    assign ovf = ovf_q;

    // Event FIFO, first-word fall-through
    logic [EW-1:0] mem [C_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_q;
    logic [EW-1:0] last_q;
    logic [EW-1:0] wr_data;

    assign fifo_full = (fill_q == FW'(C_FIFO_DEPTH));
    assign wr_data   = {slot_type_q[grant_idx], grant_idx};
    assign evt_valid = (fill_q != '0);
    // When empty, keep presenting the most recently consumed event
    assign evt_data  = evt_valid ? mem[rd_ptr_q] : last_q;
    assign evt_fill  = fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            last_q   <= '0;
        end else begin
            if (grant_any) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem[rd_ptr_q];
            end
            case ({grant_any, rd_en})
                2'b10:   fill_q <= fill_q + FW'(1);
                2'b01:   fill_q <= fill_q - FW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grant_any) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: 100 clk per ms tick, LONG after 5 ms, 4-deep FIFO.
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [3:0] evt_data;
    logic [2:0] evt_fill;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int vectors = 0;
    int miss    = 0;
    int cyc     = 0;
    int rst_cyc = 0;

    button_event_ctrl #(
        .C_CLK_FRQ   (100000),
        .C_CHANNELS  (4),
        .C_LONG_MS   (5),
        .C_REPEAT_MS (2),
        .C_FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_data (evt_data),
        .evt_fill (evt_fill),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst     = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_at(input string tag, input int n, input logic [3:0] exp);
        step(n);
        vectors++;
        assert (evt_valid === 1'b1 && evt_data === exp) else begin
            miss++;
            $error("FAIL %s: observed valid=%b data=%b, expected valid=1 data=%b",
                   tag, evt_valid, evt_data, exp);
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (evt_valid !== 1'b0) seen++;
        end
        vectors++;
        assert (seen == 0) else begin
            miss++;
            $error("FAIL %s: observed %0d cycles with evt_valid set, expected 0", tag, seen);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_data", evt_data, 0);
        check("rst_fill", evt_fill, 0);
        check("rst_ovf", ovf, 0);

        // 1: short press on ch0, two-cycle latency, no LONG
        btn = 4'b0001;
        step(1);
        check("t1_latency", evt_valid, 0);
        expect_at("t1_press", 1, 4'b0000);
        check("t1_fill", evt_fill, 1);
        expect_quiet("t1_hold", 300);
        btn = 4'b0000;
        step(1);
        check("t1_rel_latency", evt_valid, 0);
        expect_at("t1_release", 1, 4'b0100);
        step(1);

        // 2: long press on ch2, rise placed 49 cycles before a tick edge
        while (((cyc - rst_cyc) % 100) != 50) step(1);
        btn = 4'b0100;
        expect_at("t2_press", 2, 4'b0010);
        expect_quiet("t2_before_long", 448);
        expect_at("t2_long", 1, 4'b1010);
`ifdef BTN_EVT_REPEAT_EN
        expect_quiet("t2_before_rep1", 199);
        expect_at("t2_repeat1", 1, 4'b1110);
        expect_quiet("t2_before_rep2", 199);
        expect_at("t2_repeat2", 1, 4'b1110);
        expect_quiet("t2_held", 99);
`else
        expect_quiet("t2_held", 499);
`endif
        btn = 4'b0000;
        expect_at("t2_release", 2, 4'b0110);
        step(1);

        // 3: simultaneous bursts follow the round-robin pointer
        do_reset();
        btn = 4'b1111;
        expect_at("t3_p0", 2, 4'b0000);
        expect_at("t3_p1", 1, 4'b0001);
        expect_at("t3_p2", 1, 4'b0010);
        expect_at("t3_p3", 1, 4'b0011);
        btn = 4'b1101;
        expect_at("t3_r1", 2, 4'b0101);
        btn = 4'b0000;
        expect_at("t3_r2", 2, 4'b0110);
        expect_at("t3_r3", 1, 4'b0111);
        expect_at("t3_r0", 1, 4'b0100);
        step(1);
        check("t3_empty", evt_fill, 0);

        // 4: backpressure fills FIFO and slots, extra edge overflows, then drain
        evt_ready = 1'b0;
        btn       = 4'b1111;
        step(5);
        check("t4_full", evt_fill, 4);
        check("t4_head", evt_data, 4'b0001);
        btn = 4'b0000;
        step(1);
        btn = 4'b0001;
        step(1);
        check("t4_ovf", ovf, 1);
        step(3);
        check("t4_still_full", evt_fill, 4);
        // 5: read and write in the same cycle while full
        evt_ready = 1'b1;
        step(1);
        check("t5_fill_kept", evt_fill, 4);
        check("t5_head_p2", evt_data, 4'b0010);
        expect_at("t4_p3", 1, 4'b0011);
        expect_at("t4_p0", 1, 4'b0000);
        expect_at("t4_r1", 1, 4'b0101);
        check("t4_fill_last_write", evt_fill, 4);
        expect_at("t4_r2", 1, 4'b0110);
        check("t4_fill_3", evt_fill, 3);
        expect_at("t4_r3", 1, 4'b0111);
        expect_at("t4_r0", 1, 4'b0100);
        step(1);
        check("t4_drained", evt_valid, 0);
        check("t4_data_hold", evt_data, 4'b0100);
        check("t4_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", ovf, 0);

        // 6: reset with events queued and buttons held
        evt_ready = 1'b0;
        btn       = 4'b0000;
        step(1);
        btn = 4'b0011;
        step(3);
        check("t6_queued", evt_fill, 3);
        check("t6_head", evt_data, 4'b0100);
        do_reset();
        check("t6_valid", evt_valid, 0);
        check("t6_fill", evt_fill, 0);
        check("t6_ovf", ovf, 0);
        check("t6_data", evt_data, 0);
        evt_ready = 1'b1;
        expect_quiet("t6_no_press", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
